// File: rtl/password_lock_pkg.sv
// Shared types and display glyphs for the multi-digit password lock controller.
package password_lock_pkg;

   typedef enum logic [1:0] {
      ST_ENTRY,
      ST_CHECK,
      ST_UNLOCKED,
      ST_LOCKOUT
   } state_e;

   // Segment order gfedcba, active-high
   localparam logic [6:0] GLYPH_BLANK = 7'h00;
   localparam logic [6:0] GLYPH_DASH  = 7'h40;
   localparam logic [6:0] GLYPH_O     = 7'h5C;

   localparam logic [6:0] HEX_FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational keypad digit to seven-segment hex glyph; digits above F decode blank.
module seg7_hex_decoder
   import password_lock_pkg::*;
#(
   parameter int unsigned DIGIT_W = 4
) (
   input  logic [DIGIT_W-1:0] digit,
   output logic [6:0]         seg_c
);

   if (DIGIT_W > 4) begin : g_wide
      always_comb seg_c = (digit[DIGIT_W-1:4] == '0) ? HEX_FONT[digit[3:0]] : GLYPH_BLANK;
   end else begin : g_narrow
      always_comb seg_c = HEX_FONT[4'(digit)];
   end

endmodule

// File: rtl/password_lock_ctrl.sv
// Multi-digit password lock: digit collection, passcode check, timed unlock window,
// timed lockout after repeated failures, and passcode reprogramming while unlocked.
module password_lock_ctrl
   import password_lock_pkg::*;
#(
   parameter int unsigned DIGIT_W        = 4,
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned MAX_ATTEMPTS   = 3,
   parameter int unsigned UNLOCK_CYCLES  = 500,
   parameter int unsigned LOCKOUT_CYCLES = 1000,
   parameter logic [NUM_DIGITS*DIGIT_W-1:0] PASSCODE = 16'h1234,
   localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    digit_valid,
   input  logic [DIGIT_W-1:0]      digit_in,
   input  logic                    enter,
   input  logic                    clear,
   input  logic                    program_en,
   input  logic                    relock,
   output logic                    unlock,
   output logic                    locked,
   output logic [ATT_W-1:0]        attempts,
   output logic [7*NUM_DIGITS-1:0] seg
);

   localparam int unsigned BUF_W     = NUM_DIGITS * DIGIT_W;
   localparam int unsigned CNT_W     = $clog2(NUM_DIGITS + 1);
   localparam int unsigned TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                        : LOCKOUT_CYCLES;
   localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

   state_e             state_q, state_d;
   logic [BUF_W-1:0]   code_buf_q, code_buf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BUF_W-1:0]   pass_q, pass_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [ATT_W-1:0]   att_q, att_d;

   logic                    full_c;
   logic [BUF_W-1:0]        shifted_c;
   logic [7*NUM_DIGITS-1:0] seg_c;
   logic [6:0]              hex_c [NUM_DIGITS];

   // Newest digit lands in the low bits, so the first-entered digit ends up most significant
   assign full_c    = (cnt_q == CNT_W'(NUM_DIGITS));
   assign shifted_c = (code_buf_q << DIGIT_W) | BUF_W'(digit_in);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_ENTRY;
         code_buf_q <= '0;
         cnt_q      <= '0;
         pass_q     <= PASSCODE;
         timer_q    <= '0;
         att_q      <= '0;
      end else begin
         state_q    <= state_d;
         code_buf_q <= code_buf_d;
         cnt_q      <= cnt_d;
         pass_q     <= pass_d;
         timer_q    <= timer_d;
         att_q      <= att_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      code_buf_d = code_buf_q;
      cnt_d      = cnt_q;
      pass_d     = pass_q;
      timer_d    = timer_q;
      att_d      = att_q;

      unique case (state_q)
         ST_ENTRY: begin
            if (clear) begin
               code_buf_d = '0;
               cnt_d      = '0;
            end else if (enter) begin
               state_d = ST_CHECK;
            end else if (digit_valid && !full_c) begin
               code_buf_d = shifted_c;
               cnt_d      = cnt_q + 1'b1;
            end
         end

         ST_CHECK: begin
            code_buf_d = '0;
            cnt_d      = '0;
            if (full_c && (code_buf_q == pass_q)) begin
               att_d   = '0;
               state_d = ST_UNLOCKED;
               timer_d = TIMER_W'(UNLOCK_CYCLES);
            end else if (att_q == ATT_W'(MAX_ATTEMPTS - 1)) begin
               att_d   = ATT_W'(MAX_ATTEMPTS);
               state_d = ST_LOCKOUT;
               timer_d = TIMER_W'(LOCKOUT_CYCLES);
            end else begin
               att_d   = att_q + 1'b1;
               state_d = ST_ENTRY;
            end
         end

         ST_UNLOCKED: begin
            // Leaving the window drops any half-typed digits so ENTRY starts clean
            if (relock || (timer_q <= TIMER_W'(1))) begin
               state_d    = ST_ENTRY;
               timer_d    = '0;
               code_buf_d = '0;
               cnt_d      = '0;
            end else begin
               timer_d = timer_q - 1'b1;
               if (clear) begin
                  code_buf_d = '0;
                  cnt_d      = '0;
               end else if (enter) begin
                  code_buf_d = '0;
                  cnt_d      = '0;
                  if (program_en && full_c) begin
                     pass_d  = code_buf_q;
                     timer_d = TIMER_W'(UNLOCK_CYCLES);
                  end
               end else if (digit_valid && !full_c) begin
                  code_buf_d = shifted_c;
                  cnt_d      = cnt_q + 1'b1;
               end
            end
         end

         ST_LOCKOUT: begin
            if (timer_q <= TIMER_W'(1)) begin
               state_d = ST_ENTRY;
               timer_d = '0;
               att_d   = '0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
      endcase
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      seg7_hex_decoder #(
         .DIGIT_W (DIGIT_W)
      ) u_dec (
         .digit (code_buf_q[g*DIGIT_W +: DIGIT_W]),
         .seg_c (hex_c[g])
      );
   end

   // Glyph overrides for the unlocked and lockout displays
   always_comb begin
      seg_c = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         case (state_q)
            ST_UNLOCKED: seg_c[7*i +: 7] = GLYPH_O;
            ST_LOCKOUT:  seg_c[7*i +: 7] = GLYPH_DASH;
            default:     seg_c[7*i +: 7] = (CNT_W'(i) < cnt_q) ? hex_c[i] : GLYPH_BLANK;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         unlock   <= 1'b0;
         locked   <= 1'b0;
         attempts <= '0;
         seg      <= '0;
      end else begin
         unlock   <= (state_q == ST_UNLOCKED);
         locked   <= (state_q == ST_LOCKOUT);
         attempts <= att_q;
         seg      <= seg_c;
      end
   end

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Randomized and directed bench for password_lock_ctrl against a queue-based behavioural model.
module tb_password_lock_ctrl;

   localparam int unsigned DW = 4;
   localparam int unsigned ND = 4;
   localparam int unsigned MA = 3;
   localparam int unsigned UC = 8;
   localparam int unsigned LC = 16;

   logic        clk         = 1'b0;
   logic        reset       = 1'b0;
   logic        digit_valid = 1'b0;
   logic [3:0]  digit_in    = '0;
   logic        enter       = 1'b0;
   logic        clear       = 1'b0;
   logic        program_en  = 1'b0;
   logic        relock      = 1'b0;
   logic        unlock;
   logic        locked;
   logic [1:0]  attempts;
   logic [27:0] seg;

   int checks = 0;
   int errors = 0;

   password_lock_ctrl #(
      .DIGIT_W        (DW),
      .NUM_DIGITS     (ND),
      .MAX_ATTEMPTS   (MA),
      .UNLOCK_CYCLES  (UC),
      .LOCKOUT_CYCLES (LC),
      .PASSCODE       (16'h1234)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .digit_valid (digit_valid),
      .digit_in    (digit_in),
      .enter       (enter),
      .clear       (clear),
      .program_en  (program_en),
      .relock      (relock),
      .unlock      (unlock),
      .locked      (locked),
      .attempts    (attempts),
      .seg         (seg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int  m_digits[$];
   int  m_code[4];
   bit  m_checking;
   int  m_unlock_left;
   int  m_lock_left;
   int  m_fail;

   logic        exp_unlock;
   logic        exp_locked;
   logic [1:0]  exp_att;
   logic [27:0] exp_seg;

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;   3: return 7'h4F;
         4: return 7'h66;   5: return 7'h6D;   6: return 7'h7D;   7: return 7'h07;
         8: return 7'h7F;   9: return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
        12: return 7'h39;  13: return 7'h5E;  14: return 7'h79;  15: return 7'h71;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [27:0] model_seg();
      logic [27:0] s;
      s = '0;
      for (int i = 0; i < ND; i++) begin
         if (m_unlock_left > 0)        s[7*i +: 7] = 7'h5C;
         else if (m_lock_left > 0)     s[7*i +: 7] = 7'h40;
         else if (i < m_digits.size()) s[7*i +: 7] = glyph(m_digits[m_digits.size()-1-i]);
      end
      return s;
   endfunction

   function automatic bit code_matches();
      if (m_digits.size() != ND) return 1'b0;
      for (int k = 0; k < ND; k++)
         if (m_digits[k] != m_code[k]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_digits.delete();
      m_code        = '{1, 2, 3, 4};
      m_checking    = 1'b0;
      m_unlock_left = 0;
      m_lock_left   = 0;
      m_fail        = 0;
   endtask

   task automatic model_step();
      if (m_lock_left > 0) begin
         m_lock_left--;
         if (m_lock_left == 0) m_fail = 0;
      end else if (m_checking) begin
         m_checking = 1'b0;
         if (code_matches()) begin
            m_fail        = 0;
            m_unlock_left = UC;
         end else begin
            m_fail++;
            if (m_fail == MA) m_lock_left = LC;
         end
         m_digits.delete();
      end else if (m_unlock_left > 0) begin
         if (relock) begin
            m_unlock_left = 0;
            m_digits.delete();
         end else begin
            m_unlock_left--;
            if (m_unlock_left == 0) m_digits.delete();
            else if (clear) m_digits.delete();
            else if (enter) begin
               if (program_en && m_digits.size() == ND) begin
                  for (int k = 0; k < ND; k++) m_code[k] = m_digits[k];
                  m_unlock_left = UC;
               end
               m_digits.delete();
            end else if (digit_valid && m_digits.size() < ND) m_digits.push_back(int'(digit_in));
         end
      end else begin
         if (clear) m_digits.delete();
         else if (enter) m_checking = 1'b1;
         else if (digit_valid && m_digits.size() < ND) m_digits.push_back(int'(digit_in));
      end
   endtask

   // Outputs lag the model by one edge: predict from the pre-edge view, then advance
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         model_reset();
         exp_unlock = 1'b0;
         exp_locked = 1'b0;
         exp_att    = '0;
         exp_seg    = '0;
      end else begin
         exp_unlock = (m_unlock_left > 0);
         exp_locked = (m_lock_left > 0);
         exp_att    = 2'(m_fail);
         exp_seg    = model_seg();
         model_step();
      end
   end

   always @(negedge clk) begin
      chk("unlock",   32'(unlock),   32'(exp_unlock));
      chk("locked",   32'(locked),   32'(exp_locked));
      chk("attempts", 32'(attempts), 32'(exp_att));
      chk("seg",      32'(seg),      32'(exp_seg));
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit dv, input int d, input bit en, input bit cl, input bit rl);
      digit_valid = dv;
      digit_in    = 4'(d);
      enter       = en;
      clear       = cl;
      relock      = rl;
      step();
      digit_valid = 1'b0;
      enter       = 1'b0;
      clear       = 1'b0;
      relock      = 1'b0;
   endtask

   task automatic key(input int d);
      drive(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic submit(input int a, input int b, input int c, input int d);
      key(a); key(b); key(c); key(d);
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic settle();
      step();
      step();
   endtask

   localparam logic [27:0] ALL_O    = {4{7'h5C}};
   localparam logic [27:0] ALL_DASH = {4{7'h40}};

   int n;
   int r;

   initial begin
      step();
      step();
      chk("rst_unlock",   32'(unlock),   0);
      chk("rst_locked",   32'(locked),   0);
      chk("rst_attempts", 32'(attempts), 0);
      chk("rst_seg",      32'(seg),      0);
      reset = 1'b1;
      step();

      // Correct code: unlock two edges after enter, held exactly UC cycles
      submit(1, 2, 3, 4);
      chk("s1_unlock_n0", 32'(unlock), 0);
      step();
      chk("s1_unlock_n1", 32'(unlock), 0);
      step();
      chk("s1_unlock_n2", 32'(unlock), 1);
      chk("s1_seg_o",     32'(seg), 32'(ALL_O));
      chk("s1_attempts",  32'(attempts), 0);
      n = 1;
      while (unlock === 1'b1 && n < 50) begin
         step();
         if (unlock === 1'b1) n++;
      end
      chk("s1_unlock_len", n, UC);

      // Three failures -> lockout; correct code ignored while locked out
      submit(0, 0, 0, 0);
      settle();
      chk("s2_att1", 32'(attempts), 1);
      chk("s2_not_locked", 32'(locked), 0);
      submit(15, 15, 15, 15);
      settle();
      chk("s2_att2", 32'(attempts), 2);
      key(1); key(2); key(3);
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
      settle();
      chk("s2_locked", 32'(locked), 1);
      chk("s2_seg_dash", 32'(seg), 32'(ALL_DASH));
      chk("s2_att3", 32'(attempts), 3);
      n = 1;
      submit(1, 2, 3, 4);
      n += 5;
      chk("s2_ignored", 32'(locked), 1);
      chk("s2_ignored_unlock", 32'(unlock), 0);
      while (locked === 1'b1 && n < 100) begin
         step();
         if (locked === 1'b1) n++;
      end
      chk("s2_lock_len", n, LC);
      chk("s2_att_cleared", 32'(attempts), 0);

      // Reprogram to ABCD, old code fails, new code works, reset restores 1234
      submit(1, 2, 3, 4);
      settle();
      chk("s3_unlock", 32'(unlock), 1);
      program_en = 1'b1;
      submit(10, 11, 12, 13);
      program_en = 1'b0;
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
      step();
      chk("s3_relocked", 32'(unlock), 0);
      submit(1, 2, 3, 4);
      settle();
      chk("s3_old_fails", 32'(unlock), 0);
      chk("s3_old_att", 32'(attempts), 1);
      submit(10, 11, 12, 13);
      settle();
      chk("s3_new_unlocks", 32'(unlock), 1);
      chk("s3_new_att", 32'(attempts), 0);
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      submit(1, 2, 3, 4);
      settle();
      chk("s3_reset_code", 32'(unlock), 1);
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
      step();

      // Clear, fifth digit dropped, digit with enter dropped
      key(1); key(2);
      drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
      key(1); key(2); key(3); key(4); key(5);
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
      settle();
      chk("s4_fifth_dropped", 32'(unlock), 1);
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
      step();
      key(1); key(2); key(3);
      drive(1'b1, 4, 1'b1, 1'b0, 1'b0);
      settle();
      chk("s4_enter_digit_unlock", 32'(unlock), 0);
      chk("s4_enter_digit_att", 32'(attempts), 1);
      submit(1, 2, 3, 4);
      settle();
      chk("s4_unlock", 32'(unlock), 1);
      chk("s4_att", 32'(attempts), 0);

      // Relock on second unlocked cycle, then async reset during lockout
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
      chk("s5_still_unlocked", 32'(unlock), 1);
      step();
      chk("s5_relock", 32'(unlock), 0);
      submit(0, 0, 0, 0); settle();
      submit(0, 0, 0, 0); settle();
      submit(0, 0, 0, 0); settle();
      chk("s5_locked", 32'(locked), 1);
      step(); step(); step();
      reset = 1'b0;
      #1;
      chk("s5_async_locked", 32'(locked), 0);
      chk("s5_async_att", 32'(attempts), 0);
      chk("s5_async_seg", 32'(seg), 0);
      step();
      reset = 1'b1;
      step();

      // Randomized phase: mix of correct codes, noise, program/relock and rare resets
      for (int it = 0; it < 2500; it++) begin
         r = int'($urandom_range(0, 99));
         if (r < 10 && m_lock_left == 0) begin
            for (int k = 0; k < ND; k++) key(m_code[k]);
            drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
         end else if (r == 10) begin
            reset = 1'b0;
            step();
            reset = 1'b1;
         end else begin
            if ($urandom_range(0, 19) == 0) program_en = ~program_en;
            drive($urandom_range(0, 9) < 4, int'($urandom_range(0, 15)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 29) == 0);
         end
      end

      program_en = 1'b0;
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/password_lock_ctrl.md
# password_lock_ctrl

Parametrised multi-digit password lock controller, the successor to the single-nibble `password_lock_system`. It takes a keypad digit stream and collects NUM_DIGITS digits. On `enter` it compares them against a stored passcode. It drives unlock/lockout status, an attempt counter, and per-digit seven-segment outputs. Beyond the original block it adds a timed auto-relock, a timed lockout after MAX_ATTEMPTS failures, and passcode reprogramming while unlocked.

## Interface
- DIGIT_W, 4: bits per keypad digit.
- NUM_DIGITS, 4: digits per passcode and number of display digits.
- MAX_ATTEMPTS, 3: consecutive failures that trigger lockout (≥1).
- UNLOCK_CYCLES, 500: cycles `unlock` stays high before auto-relock (≥1).
- LOCKOUT_CYCLES, 1000: cycles of lockout (≥1).
- PASSCODE, 16'h1234: reset passcode, NUM_DIGITS*DIGIT_W bits. Most significant digit is entered first.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- digit_valid  in  1  one-cycle strobe: digit_in is valid.
- digit_in  in  DIGIT_W  keypad digit.
- enter  in  1  one-cycle strobe: submit buffer.
- clear  in  1  one-cycle strobe: discard buffer.
- program_en  in  1  level: while unlocked, `enter` stores the buffer as the new passcode.
- relock  in  1  one-cycle strobe: end the unlocked window early.
- unlock  out  1  high in UNLOCKED.
- locked  out  1  high in LOCKOUT.
- attempts  out  $clog2(MAX_ATTEMPTS+1)  consecutive failure count.
- seg  out  7*NUM_DIGITS  seven-segment patterns. Digit 0 is in bits [6:0] and is the most recently entered digit. Segments are active-high, order gfedcba.

## Operation
- FSM states: ENTRY, CHECK, UNLOCKED, LOCKOUT.
- ENTRY:
  - `digit_valid` shifts `digit_in` into the buffer and increments `cnt`.
  - Once `cnt`==NUM_DIGITS, further digits are dropped and `cnt` saturates.
  - `clear` empties the buffer.
  - `enter` moves to CHECK.
- CHECK (one cycle):
  - Match requires `cnt`==NUM_DIGITS and buffer==passcode. On match: `attempts`←0, go to UNLOCKED, load the timer with UNLOCK_CYCLES.
  - On a mismatch, an incomplete entry counts as a failure: `attempts`+1.
  - If the new `attempts` value equals MAX_ATTEMPTS, go to LOCKOUT and load the timer with LOCKOUT_CYCLES. Otherwise return to ENTRY.
  - The buffer is always emptied on leaving CHECK.
- UNLOCKED:
  - The timer counts down; at expiry go to ENTRY.
  - `relock` goes to ENTRY immediately.
  - Digits are still collected.
  - `enter` with `program_en`=1 and `cnt`==NUM_DIGITS: passcode←buffer, buffer emptied, stay UNLOCKED, timer reloaded.
  - `enter` without `program_en`, or with an incomplete buffer: buffer emptied, no other effect.
- LOCKOUT:
  - All inputs are ignored.
  - At timer expiry: `attempts`←0, go to ENTRY.
- Priority within one cycle: `clear` > `enter` > `digit_valid`. A digit arriving in the same cycle as enter or clear is dropped. In UNLOCKED, `relock` beats everything.
- Display:
  - ENTRY/CHECK: filled positions show the hex glyph of the digit; unfilled positions are blank (7'h00).
  - UNLOCKED: every digit shows the "o" glyph (7'h5C).
  - LOCKOUT: every digit shows a dash (7'h40).
  - Glyphs for 0–F are the standard hex font.
- Reset values: unlock=0, locked=0, attempts=0, seg all 7'h00, buffer empty, state ENTRY, passcode=PASSCODE.
  - Reset asserted mid-operation returns the block to these values, including a passcode that was reprogrammed.

## Timing
- All outputs are registered.
- `enter` sampled at edge N: CHECK at N+1. `unlock` (or `locked`, or the `attempts` update) is visible after edge N+2.
- `unlock` is high for exactly UNLOCK_CYCLES cycles unless `relock` cuts the window short. `relock` sampled at edge M: `unlock` low after edge M+1.
- `locked` is high for exactly LOCKOUT_CYCLES cycles.
- `seg` updates one cycle after the buffer or state changes.
- Timer width is $clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1). There is no wrap; the timer stops at 0.

## Structure
- Package `password_lock_pkg` holds:
  - the FSM state enum;
  - the glyph constants: blank, dash, "o", and the hex font array.
- Sub-module `seg7_hex_decoder`: combinational DIGIT_W→7 decode, instantiated NUM_DIGITS times. The parent handles glyph overrides.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, PASSCODE=16'h1234, MAX_ATTEMPTS=3, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16.
- Reset release, then keys 1,2,3,4 and enter → `unlock`=1 two cycles after enter, held exactly 8 cycles, `attempts`=0, `seg` all 7'h5C.
- Three wrong entries (0,0,0,0 / F,F,F,F / 3 digits only) → `attempts` steps 1,2. The third failure gives `locked`=1 for 16 cycles and `seg` all 7'h40. Correct keys during lockout are ignored. Afterwards `attempts`=0.
- Unlock, hold `program_en`, enter A,B,C,D → relock. Old code 1234 now fails and ABCD unlocks. Reset → 1234 unlocks again.
- Keys 1,2,clear,1,2,3,4,5,enter → unlocks: the 5th digit is dropped. `digit_valid` together with `enter` → that digit is ignored.
- Unlocked and `relock` pulsed on cycle 2 → `unlock` low after next edge. Reset asserted mid-lockout → `locked`=0, `attempts`=0 immediately (asynchronously).
